// File: rtl/alu_seq_ctrl.sv
// Byte-serial sequencer for alu_8bits: loads opcode, A and B from one bus,
// runs one execute cycle and holds the result under a valid/ready handshake.
module alu_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_s,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err,
  output logic [7:0]       done_cnt
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    HOLD
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            xfer;
  logic            to_hit;

  assign din_ready = ena && (state == IDLE ||
                             state == LOAD_A ||
                             state == LOAD_B);
  assign xfer      = din_valid && din_ready;
  assign to_hit    = (wait_cnt == CW'(TIMEOUT - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      done_cnt  <= '0;
      wait_cnt  <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            alu_s    <= din[OP_W-1:0];
            err      <= 1'b0;
            wait_cnt <= '0;
            state    <= LOAD_A;
          end
        end
        LOAD_A, LOAD_B: begin
          // An accepted byte beats a timeout landing in the same cycle.
          if (xfer) begin
            wait_cnt <= '0;
            if (state == LOAD_A) begin
              alu_a <= din;
              state <= LOAD_B;
            end else begin
              alu_b <= din;
              state <= EXEC;
            end
          end else if (to_hit) begin
            wait_cnt <= '0;
            err      <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EXEC: begin
          res       <= alu_result;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
